// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory bus of the load/store unit.
// master = CPU plus memory side, slave = load_store_unit.
interface load_store_unit_if #(
   parameter int mem_add_width = 32,
   parameter int mem_width     = 32
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_write;
   logic [1:0]               req_size;
   logic                     req_signed;
   logic [31:0]              req_addr;
   logic [mem_width-1:0]     req_wdata;
   logic                     rsp_valid;
   logic [mem_width-1:0]     rsp_rdata;
   logic                     rsp_err;
   logic                     wr_en_mem;
   logic [mem_add_width-1:0] add_mem;
   logic [mem_width-1:0]     wrd_mem;
   logic [mem_width-1:0]     rdd_mem;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rdd_mem,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_en_mem, add_mem, wrd_mem
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rdd_mem,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_en_mem, add_mem, wrd_mem
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit with read-modify-write for sub-word stores.
// Response 2 cycles after accept (3 for sub-word stores, 1 for errors); req_ready only in IDLE, no response backpressure.
module load_store_unit #(
   parameter int mem_add_width = 32,
   parameter int mem_width     = 32
) (
   input  logic               clk,
   input  logic               rst,
   load_store_unit_if.slave   bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] WRITE  = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0]           state;
   logic                 l_write;
   logic                 l_signed;
   logic                 l_err;
   logic [1:0]           l_size;
   logic [31:0]          l_addr;
   logic [mem_width-1:0] l_wdata;
   logic [mem_width-1:0] merge_q;
   logic [mem_width-1:0] rdata_q;

   logic                 req_err;
   logic                 accept;
   logic                 sub_store;
   logic [31:0]          word_idx;
   logic [7:0]           byte_sel;
   logic [15:0]          half_sel;
   logic [mem_width-1:0] load_val;
   logic [mem_width-1:0] merge_val;

   assign req_err = (bus.req_size == 2'b11)
                  | ((bus.req_size == 2'b01) & bus.req_addr[0])
                  | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
   assign accept    = bus.req_valid & (state == IDLE);
   assign sub_store = l_write & (l_size != 2'b10);
   assign word_idx  = {2'b00, l_addr[31:2]};

   assign byte_sel = 8'(bus.rdd_mem >> {l_addr[1:0], 3'b000});
   assign half_sel = l_addr[1] ? bus.rdd_mem[31:16] : bus.rdd_mem[15:0];

   always_comb begin
      load_val = bus.rdd_mem;
      case (l_size)
         2'b00:   load_val = l_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
         2'b01:   load_val = l_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
         default: load_val = bus.rdd_mem;
      endcase
   end

   // Replace only the addressed lane(s) of the word captured in ACCESS.
   always_comb begin
      merge_val = merge_q;
      if (l_size == 2'b00)
         merge_val[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
      else if (l_size == 2'b01)
         merge_val[{l_addr[1], 4'b0000} +: 16] = l_wdata[15:0];
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = (state == RESP) ? rdata_q : '0;
   assign bus.rsp_err   = (state == RESP) & l_err;
   assign bus.wr_en_mem = !rst & (((state == ACCESS) & l_write & !sub_store) | (state == WRITE));
   assign bus.wrd_mem   = !bus.wr_en_mem ? '0 : ((state == WRITE) ? merge_val : l_wdata);
   assign bus.add_mem   = ((state == ACCESS) | (state == WRITE)) ? mem_add_width'(word_idx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         l_write  <= 1'b0;
         l_signed <= 1'b0;
         l_err    <= 1'b0;
         l_size   <= 2'b00;
         l_addr   <= 32'h0;
         l_wdata  <= '0;
         merge_q  <= '0;
         rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  l_write  <= bus.req_write;
                  l_signed <= bus.req_signed;
                  l_size   <= bus.req_size;
                  l_addr   <= bus.req_addr;
                  l_wdata  <= bus.req_wdata;
                  l_err    <= req_err;
                  rdata_q  <= '0;
                  state    <= req_err ? RESP : ACCESS;
               end
            end
            ACCESS: begin
               if (!l_write) begin
                  rdata_q <= load_val;
                  state   <= RESP;
               end else if (sub_store) begin
                  merge_q <= bus.rdd_mem;
                  state   <= WRITE;
               end else begin
                  state   <= RESP;
               end
            end
            WRITE:   state <= RESP;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: memory model, response scoreboard, latency and write tracking.
module tb_load_store_unit;
   logic clk;
   logic rst;

   load_store_unit_if #(.mem_add_width(32), .mem_width(32)) bus ();

   load_store_unit #(.mem_add_width(32), .mem_width(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          checks;
   int          failures;

   logic [31:0] mem [0:63];
   logic        pre_en;
   logic [5:0]  pre_idx;
   logic [31:0] pre_dat;

   always @(posedge clk) begin
      if (pre_en)
         mem[pre_idx] <= pre_dat;
      else if (bus.wr_en_mem && bus.add_mem < 32'd64)
         mem[bus.add_mem[5:0]] <= bus.wrd_mem;
   end

   always_comb begin
      bus.rdd_mem = 32'h0;
      if (bus.add_mem < 32'd64)
         bus.rdd_mem = mem[bus.add_mem[5:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
      @(negedge clk);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_dat = dat;
      @(negedge clk);
      pre_en  = 1'b0;
   endtask

   // e_wc: cycle after acceptance in which the single write is expected (0 = no write).
   task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                         input int e_wc, input logic [31:0] e_wd);
      exp_t        e;
      int          got, nwr, wcyc, waits;
      logic [31:0] acc_a, wa, wdv, rd;
      logic        er;
      e.rdata = e_rdata;
      e.err   = e_err;
      e.lat   = e_lat;
      sb.push_back(e);
      got = 0; nwr = 0; wcyc = 0; waits = 0;
      acc_a = 32'h0; wa = 32'h0; wdv = 32'h0; rd = 32'h0; er = 1'b0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      while (!bus.req_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      chk({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
      for (int c = 1; c <= 10 && got == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus.req_valid = 1'b0;
            acc_a = bus.add_mem;
         end
         if (bus.wr_en_mem) begin
            nwr++;
            wcyc = c;
            wa   = bus.add_mem;
            wdv  = bus.wrd_mem;
         end else begin
            chk({tag, "_wrd_zero"}, bus.wrd_mem, 32'h0);
         end
         if (bus.rsp_valid) begin
            got = c;
            rd  = bus.rsp_rdata;
            er  = bus.rsp_err;
         end
      end
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
      e = sb.pop_front();
      chk({tag, "_lat"}, 32'(got), 32'(e.lat));
      chk({tag, "_rdata"}, rd, e.rdata);
      chk({tag, "_err"}, 32'(er), 32'(e.err));
      chk({tag, "_nwr"}, 32'(nwr), (e_wc != 0) ? 32'd1 : 32'd0);
      chk({tag, "_acc_addr"}, acc_a, e_err ? 32'h0 : (a >> 2));
      if (e_wc != 0) begin
         chk({tag, "_wr_cyc"}, 32'(wcyc), 32'(e_wc));
         chk({tag, "_wr_addr"}, wa, a >> 2);
         chk({tag, "_wr_data"}, wdv, e_wd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   nacc, nrsp;
      int   acc_idx[$];
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      pre_en   = 1'b0;
      pre_idx  = 6'd0;
      pre_dat  = 32'h0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_wr_en", 32'(bus.wr_en_mem), 32'd0);
      chk("rst_add", bus.add_mem, 32'h0);
      chk("rst_wrd", bus.wrd_mem, 32'h0);

      do_req("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'hDEADBEEF);
      do_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0);

      preload(6'd4, 32'h11223344);
      do_req("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 32'h0, 1'b0, 3, 2, 32'h1122AA44);
      do_req("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122AA44, 1'b0, 2, 0, 32'h0);

      preload(6'd4, 32'h80FF7F01);
      do_req("lb_s_12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0, 32'h0);
      do_req("lh_u_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h000080FF, 1'b0, 2, 0, 32'h0);
      do_req("lh_s_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00007F01, 1'b0, 2, 0, 32'h0);
      do_req("lb_u_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, 0, 32'h0);
      do_req("lb_s_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 32'h0);

      do_req("lw_mis_13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
      do_req("sh_mis_05", 1'b1, 2'b01, 1'b0, 32'h05, 32'h0000BEEF, 32'h0, 1'b1, 1, 0, 32'h0);
      do_req("size11_20", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);

      preload(6'd5, 32'hAABBCCDD);
      do_req("sh_16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234CAFE, 32'h0, 1'b0, 3, 2, 32'hCAFECCDD);
      chk("mem5_after_sh", mem[5], 32'hCAFECCDD);

      // Reset lands in the WRITE cycle of a byte store.
      preload(6'd6, 32'h01020304);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h19;
      bus.req_wdata  = 32'h00000055;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rstw_pre_wr_en", 32'(bus.wr_en_mem), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstw_gated_wr_en", 32'(bus.wr_en_mem), 32'd0);
      chk("rstw_gated_wrd", bus.wrd_mem, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("rstw_ready", 32'(bus.req_ready), 32'd1);
      chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rstw_rdata", bus.rsp_rdata, 32'h0);
      chk("rstw_err", 32'(bus.rsp_err), 32'd0);
      chk("rstw_wr_en", 32'(bus.wr_en_mem), 32'd0);
      chk("rstw_add", bus.add_mem, 32'h0);
      chk("rstw_wrd", bus.wrd_mem, 32'h0);
      chk("rstw_mem6", mem[6], 32'h01020304);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstw_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end

      // req_valid held high: acceptances every 3 cycles, one response each.
      bus.req_write  = 1'b0;
      bus.req_size   = 2'b10;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h10;
      @(negedge clk);
      bus.req_valid = 1'b1;
      nacc = 0;
      nrsp = 0;
      for (int i = 0; i < 20; i++) begin
         if (nacc == 4) bus.req_valid = 1'b0;
         if (bus.rsp_valid) begin
            nrsp++;
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("b2b_rdata", bus.rsp_rdata, e.rdata);
               chk("b2b_lat", 32'(i), 32'(e.lat));
            end
         end
         if (bus.req_valid && bus.req_ready) begin
            acc_idx.push_back(i);
            nacc++;
            e.rdata = 32'h80FF7F01;
            e.err   = 1'b0;
            e.lat   = i + 2;
            sb.push_back(e);
         end
         @(negedge clk);
      end
      chk("b2b_nacc", 32'(nacc), 32'd4);
      chk("b2b_nrsp", 32'(nrsp), 32'd4);
      for (int k = 0; k + 1 < acc_idx.size(); k++)
         chk("b2b_spacing", 32'(acc_idx[k+1] - acc_idx[k]), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
